// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the register file write-back block.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DONE     = 2'd2
    } wb_state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int NUM_REGS_DEF    = 8;
    localparam int MEM_TIMEOUT_DEF = 15;

    // Width of a counter able to hold the value 'limit'.
    function automatic int count_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage: two combinational read ports, one write port, register 0 reads as zero.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] rf_reg [NUM_REGS];
    logic [AW-1:0]     raddr  [2];
    logic [DATA_W-1:0] rdata  [2];

    // Register 0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            rf_reg[waddr] <= wdata;
        end
    end

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : rf_reg[raddr[gi]];
        end
    endgenerate

    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: FSM, load timeout counter, source mux and register file.
// Optional same-cycle read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ReadReg1,
    input  logic [AW-1:0]     ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              wb_valid,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [AW-1:0]     WriteReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic              mem_valid,
    output logic              wb_busy,
    output logic              wb_done,
    output logic              wb_err
);

    localparam int CW = count_width(MEM_TIMEOUT);

    wb_state_t         state_reg;
    logic [AW-1:0]     wreg_reg;
    logic [CW-1:0]     cnt_reg;
    logic              wb_busy_reg;
    logic              wb_done_reg;
    logic              wb_err_reg;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    // ALU results commit straight from IDLE; load data commits from WAIT_MEM.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = WriteReg;
        rf_wdata = ALUResult;
        case (state_reg)
            IDLE: begin
                rf_we = wb_valid && RegWrite && !MemtoReg;
            end
            WAIT_MEM: begin
                rf_we    = mem_valid;
                rf_waddr = wreg_reg;
                rf_wdata = MemReadData;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            wreg_reg    <= '0;
            cnt_reg     <= '0;
            wb_busy_reg <= 1'b0;
            wb_done_reg <= 1'b0;
            wb_err_reg  <= 1'b0;
        end else begin
            wb_done_reg <= 1'b0;
            wb_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wb_valid) begin
                        wb_busy_reg <= 1'b1;
                        if (RegWrite && MemtoReg) begin
                            wreg_reg  <= WriteReg;
                            cnt_reg   <= '0;
                            state_reg <= WAIT_MEM;
                        end else begin
                            wb_done_reg <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                WAIT_MEM: begin
                    // Data arriving on the final allowed cycle still wins over the timeout.
                    if (mem_valid) begin
                        wb_done_reg <= 1'b1;
                        state_reg   <= DONE;
                    end else if (cnt_reg == CW'(MEM_TIMEOUT - 1)) begin
                        cnt_reg     <= cnt_reg + 1'b1;
                        wb_busy_reg <= 1'b0;
                        wb_err_reg  <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    wb_busy_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    wb_busy_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    regfile_core #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (ReadReg1),
        .raddr2 (ReadReg2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

`ifdef REGFILE_BYPASS_EN
    logic bypass1;
    logic bypass2;

    assign bypass1   = rf_we && (rf_waddr != '0) && (rf_waddr == ReadReg1);
    assign bypass2   = rf_we && (rf_waddr != '0) && (rf_waddr == ReadReg2);
    assign ReadData1 = bypass1 ? rf_wdata : rf_rdata1;
    assign ReadData2 = bypass2 ? rf_wdata : rf_rdata2;
`else
    assign ReadData1 = rf_rdata1;
    assign ReadData2 = rf_rdata2;
`endif

    assign wb_busy = wb_busy_reg;
    assign wb_done = wb_done_reg;
    assign wb_err  = wb_err_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table of ALU writes plus load, timeout and reset sequences.
module tb_regfile_writeback;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ReadReg1 = '0;
    logic [2:0] ReadReg2 = '0;
    logic [7:0] ReadData1;
    logic [7:0] ReadData2;
    logic       wb_valid = 1'b0;
    logic       RegWrite = 1'b0;
    logic       MemtoReg = 1'b0;
    logic [2:0] WriteReg = '0;
    logic [7:0] ALUResult = '0;
    logic [7:0] MemReadData = '0;
    logic       mem_valid = 1'b0;
    logic       wb_busy;
    logic       wb_done;
    logic       wb_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       regwrite;
        logic [2:0] wreg;
        logic [7:0] alu;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    regfile_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .wb_valid    (wb_valid),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .WriteReg    (WriteReg),
        .ALUResult   (ALUResult),
        .MemReadData (MemReadData),
        .mem_valid   (mem_valid),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
    task automatic alu_write(input logic rw, input logic [2:0] wreg, input logic [7:0] alu,
                             input logic [7:0] exp_rd, input string name);
        wb_valid  = 1'b1;
        RegWrite  = rw;
        MemtoReg  = 1'b0;
        WriteReg  = wreg;
        ALUResult = alu;
        ReadReg1  = wreg;
        ReadReg2  = wreg;
        @(negedge clk);
        wb_valid = 1'b0;
        check({name, "_done"}, wb_done, 1);
        check({name, "_busy"}, wb_busy, 1);
        check({name, "_rd1"}, ReadData1, exp_rd);
        check({name, "_rd2"}, ReadData2, exp_rd);
        @(negedge clk);
        check({name, "_done_end"}, wb_done, 0);
        check({name, "_idle"}, wb_busy, 0);
        $display("txn %s: rw=%0d reg=%0d alu=0x%02h read=0x%02h", name, rw, wreg, alu, ReadData1);
    endtask

    initial begin
        int   busy_cnt;
        int   n;
        logic seen;
        logic done_seen;
        logic [7:0] exp_byp;

        vecs[0] = '{1'b1, 3'd3, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 3'd0, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 3'd7, 8'hA5, 8'hA5};
        vecs[3] = '{1'b0, 3'd3, 8'h11, 8'h5A};
        vecs[4] = '{1'b1, 3'd1, 8'h01, 8'h01};
        vecs[5] = '{1'b1, 3'd3, 8'hFF, 8'hFF};

        // Reset state
        #12;
        ReadReg1 = 3'd3;
        ReadReg2 = 3'd7;
        #1;
        check("rst_busy", wb_busy, 0);
        check("rst_done", wb_done, 0);
        check("rst_err", wb_err, 0);
        check("rst_rd1", ReadData1, 0);
        check("rst_rd2", ReadData2, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            alu_write(vecs[i].regwrite, vecs[i].wreg, vecs[i].alu, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Same-cycle read of a register being written
        alu_write(1'b1, 3'd2, 8'h22, 8'h22, "pre_r2");
`ifdef REGFILE_BYPASS_EN
        exp_byp = 8'h77;
`else
        exp_byp = 8'h22;
`endif
        wb_valid  = 1'b1;
        RegWrite  = 1'b1;
        MemtoReg  = 1'b0;
        WriteReg  = 3'd2;
        ALUResult = 8'h77;
        ReadReg1  = 3'd2;
        ReadReg2  = 3'd0;
        #1;
        check("byp_rd1", ReadData1, exp_byp);
        check("byp_r0", ReadData2, 0);
        @(negedge clk);
        wb_valid = 1'b0;
        check("byp_after", ReadData1, 8'h77);
        check("byp_done", wb_done, 1);
        @(negedge clk);
        $display("txn bypass: r2=0x%02h", ReadData1);

        // Load with data on the 4th wait cycle; wb_valid in WAIT_MEM and mem_valid outside it are ignored
        wb_valid = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        WriteReg = 3'd5;
        ReadReg1 = 3'd5;
        ReadReg2 = 3'd6;
        busy_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (wb_busy) busy_cnt++;
            if (i == 1) wb_valid = 1'b0;
            if (i == 2) begin
                wb_valid  = 1'b1;
                MemtoReg  = 1'b0;
                WriteReg  = 3'd6;
                ALUResult = 8'h66;
            end
            if (i == 3) wb_valid = 1'b0;
            if (i == 4) begin
                check("load_pre", ReadData1, 0);
                mem_valid   = 1'b1;
                MemReadData = 8'hC3;
            end
        end
        @(negedge clk);
        if (wb_busy) busy_cnt++;
        check("load_done", wb_done, 1);
        check("load_rd", ReadData1, 8'hC3);
        MemReadData = 8'hEE;
        @(negedge clk);
        check("load_idle", wb_busy, 0);
        check("load_busy_cycles", busy_cnt, 5);
        @(negedge clk);
        mem_valid = 1'b0;
        check("load_keep", ReadData1, 8'hC3);
        check("no_queue_r6", ReadData2, 0);
        check("no_queue_busy", wb_busy, 0);
        $display("txn load: r5=0x%02h busy_cycles=%0d", ReadData1, busy_cnt);

        // Timeout: no mem_valid
        wb_valid = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        WriteReg = 3'd5;
        n = 0;
        seen = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wb_valid = 1'b0;
            if (wb_done) done_seen = 1'b1;
            if (wb_err) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        check("tmo_seen", seen, 1);
        check("tmo_cycles", n, 15);
        check("tmo_no_done", done_seen, 0);
        check("tmo_busy", wb_busy, 0);
        @(negedge clk);
        check("tmo_pulse", wb_err, 0);
        check("tmo_r5", ReadData1, 8'hC3);
        $display("txn timeout: wait_cycles=%0d r5=0x%02h", n, ReadData1);

        // mem_valid on the last allowed wait cycle is accepted
        wb_valid = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        WriteReg = 3'd4;
        ReadReg1 = 3'd4;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            wb_valid = 1'b0;
            if (i == 15) begin
                mem_valid   = 1'b1;
                MemReadData = 8'h4D;
            end
        end
        @(negedge clk);
        mem_valid = 1'b0;
        check("edge_done", wb_done, 1);
        check("edge_err", wb_err, 0);
        check("edge_rd", ReadData1, 8'h4D);
        @(negedge clk);
        check("edge_err2", wb_err, 0);
        $display("txn edge_load: r4=0x%02h", ReadData1);

        // Reset in WAIT_MEM, then a request on the first edge after release
        wb_valid = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        WriteReg = 3'd7;
        ReadReg1 = 3'd3;
        ReadReg2 = 3'd7;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", wb_busy, 1);
        rst       = 1'b1;
        mem_valid = 1'b1;
        MemReadData = 8'h99;
        #1;
        check("mid_rst_busy", wb_busy, 0);
        check("mid_rst_r3", ReadData1, 0);
        check("mid_rst_r7", ReadData2, 0);
        check("mid_rst_err", wb_err, 0);
        @(negedge clk);
        rst       = 1'b0;
        mem_valid = 1'b0;
        wb_valid  = 1'b1;
        RegWrite  = 1'b1;
        MemtoReg  = 1'b0;
        WriteReg  = 3'd1;
        ALUResult = 8'h3C;
        ReadReg1  = 3'd1;
        @(negedge clk);
        wb_valid = 1'b0;
        check("post_rst_done", wb_done, 1);
        check("post_rst_err", wb_err, 0);
        check("post_rst_r1", ReadData1, 8'h3C);
        check("post_rst_r7", ReadData2, 0);
        @(negedge clk);
        check("post_rst_idle", wb_busy, 0);
        $display("txn reset_mid_load: r1=0x%02h r7=0x%02h", ReadData1, ReadData2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DATA_W, default 8, register data width in bits.
REQ-002 Parameter NUM_REGS, default 8, number of architectural registers; the address width SHALL be clog2(NUM_REGS), which is 3 at the default.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum number of cycles spent waiting for load data.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ReadReg1  input  3  source register address, port 1.
REQ-007 ReadReg2  input  3  source register address, port 2.
REQ-008 ReadData1  output  8  combinational read data, port 1.
REQ-009 ReadData2  output  8  combinational read data, port 2.
REQ-010 wb_valid  input  1  write-back request, sampled only in IDLE.
REQ-011 RegWrite  input  1  write enable, qualified by wb_valid.
REQ-012 MemtoReg  input  1  data source select: 1 = load data, 0 = ALU result.
REQ-013 WriteReg  input  3  destination register address.
REQ-014 ALUResult  input  8  ALU result data.
REQ-015 MemReadData  input  8  load data from memory.
REQ-016 mem_valid  input  1  MemReadData is valid this cycle.
REQ-017 wb_busy  output  1  high while the FSM is not in IDLE.
REQ-018 wb_done  output  1  one-cycle pulse when a write-back commits.
REQ-019 wb_err  output  1  one-cycle pulse when a load times out.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT_MEM and DONE.
REQ-021 In IDLE, wb_valid=1 with RegWrite=1 and MemtoReg=0 SHALL write ALUResult to WriteReg on that clock edge and go to DONE.
REQ-022 In IDLE, wb_valid=1 with RegWrite=1 and MemtoReg=1 SHALL latch WriteReg, clear the timeout counter and go to WAIT_MEM.
REQ-023 In IDLE, wb_valid=1 with RegWrite=0 SHALL perform no write and go to DONE.
REQ-024 In WAIT_MEM, mem_valid=1 SHALL write MemReadData to the latched register and go to DONE.
REQ-025 In WAIT_MEM without mem_valid, the counter SHALL increment each cycle; when it reaches MEM_TIMEOUT the FSM SHALL return to IDLE with no write and pulse wb_err for one cycle.
REQ-026 If mem_valid=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, the data SHALL be accepted and no error raised.
REQ-027 DONE SHALL assert wb_done for exactly one cycle and then return to IDLE.
REQ-028 wb_valid in any non-IDLE state SHALL be ignored and SHALL NOT be queued.
REQ-029 mem_valid outside WAIT_MEM SHALL be ignored.
REQ-030 Register 0 SHALL always read 0, and writes to it SHALL be discarded; wb_done still pulses for such writes.
REQ-031 Reads SHALL be combinational, with zero latency from address to data.
REQ-032 Without bypass, a read of a register in the cycle it is written SHALL return the old value.
REQ-033 Write latency: ALU writes are visible 1 cycle after wb_valid; load writes are visible 1 cycle after mem_valid.
REQ-034 All data paths SHALL be DATA_W wide, with no extension or truncation.

Reset
REQ-035 Asserting rst SHALL immediately force: FSM to IDLE, timeout counter to 0, every register to 0x00, and wb_busy, wb_done and wb_err to 0.
REQ-036 Reset asserted during WAIT_MEM SHALL abort the load with no write and no wb_err.
REQ-037 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-038 Macro REGFILE_BYPASS_EN: when defined, a read whose address matches an in-progress nonzero write SHALL return the write data in the same cycle.
REQ-039 When REGFILE_BYPASS_EN is not defined, REQ-032 applies and no forwarding logic SHALL exist.

Structure
REQ-040 Shared package regfile_pkg SHALL hold the wb_state_t enum (IDLE, WAIT_MEM, DONE), DATA_W_DEF, NUM_REGS_DEF and MEM_TIMEOUT_DEF.
REQ-041 Sub-module regfile_core SHALL hold the storage array: two read ports and one write port, with register 0 hardwired to zero.
REQ-042 regfile_writeback SHALL contain the FSM, timeout counter, source mux and optional bypass.

Verification
REQ-043 ALU write: wb_valid, RegWrite=1, MemtoReg=0, WriteReg=3, ALUResult=0x5A -> next cycle ReadReg1=3 gives ReadData1=0x5A and wb_done pulses once.
REQ-044 Load: MemtoReg=1, WriteReg=5, mem_valid after 4 cycles with MemReadData=0xC3 -> wb_busy high for 5 cycles, then R5 reads 0xC3.
REQ-045 Timeout: MemtoReg=1 with no mem_valid -> wb_err pulses after 15 WAIT_MEM cycles and R5 is unchanged.
REQ-046 R0 protection: write 0xFF to WriteReg=0 -> ReadData2 stays 0x00 and wb_done still pulses.
REQ-047 Reset mid-load: rst in WAIT_MEM -> all registers 0x00, FSM in IDLE, no wb_err.
REQ-048 Bypass: with REGFILE_BYPASS_EN, write 0x77 to R2 while ReadReg1=2 -> ReadData1=0x77 in the same cycle; without the macro it reads the old value.
